// File: rtl/noise_lfsr_channel_if.sv
// Control and output bundle of the PSG noise channel.
// The master drives the rate tick, control writes and the tone-2 edge pulse; the slave returns the noise bit.
interface noise_lfsr_channel_if #(
    parameter int unsigned LFSR_BITS = 15
);
    logic                 clk_en;
    logic [2:0]           control;
    logic                 control_write;
    logic                 tone2_posedge;
    logic                 noise_out;
    logic                 shift_strobe;
    logic [LFSR_BITS-1:0] lfsr_state;

    modport master (
        output clk_en,
        output control,
        output control_write,
        output tone2_posedge,
        input  noise_out,
        input  shift_strobe,
        input  lfsr_state
    );

    modport slave (
        input  clk_en,
        input  control,
        input  control_write,
        input  tone2_posedge,
        output noise_out,
        output shift_strobe,
        output lfsr_state
    );
endinterface

// File: rtl/noise_lfsr_channel.sv
// SN76489-style noise channel: a 15-bit LFSR in white or periodic mode.
// It is clocked by a divided chip-rate square wave or by rising edges of tone channel 2.
module noise_lfsr_channel #(
    parameter int unsigned          LFSR_BITS = 15,
    parameter logic [LFSR_BITS-1:0] LFSR_SEED = {1'b1, {(LFSR_BITS-1){1'b0}}},
    parameter int unsigned          DIV_BASE  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    noise_lfsr_channel_if.slave   bus
);
    localparam int unsigned DIV_W   = $clog2(DIV_BASE * 4);
    localparam logic [1:0]  NF_TONE = 2'b11;

    logic                 fb_reg,   fb_nxt;
    logic [1:0]           nf_reg,   nf_nxt;
    logic [DIV_W-1:0]     divider,  divider_nxt;
    logic                 rate_sq,  rate_sq_nxt;
    logic [LFSR_BITS-1:0] lfsr,     lfsr_nxt;
    logic                 strobe_q, strobe_nxt;

    logic [DIV_W-1:0]     half_m1_c;
    logic                 div_wrap_c;
    logic                 shift_ev_c;
    logic                 fbk_c;

    // Terminal count of the divider; NF=11 keeps it free-running at the slowest rate.
    always_comb begin
        half_m1_c = DIV_W'(DIV_BASE * 4 - 1);
        case (nf_reg)
            2'b00:   half_m1_c = DIV_W'(DIV_BASE - 1);
            2'b01:   half_m1_c = DIV_W'(DIV_BASE * 2 - 1);
            default: half_m1_c = DIV_W'(DIV_BASE * 4 - 1);
        endcase
    end

    assign div_wrap_c = (divider == half_m1_c);
    assign fbk_c      = fb_reg ? (lfsr[0] ^ lfsr[1]) : lfsr[0];

    // A shift happens on the rising edge of the rate square wave, or on a tone-2 edge in NF=11.
    always_comb begin
        if (nf_reg == NF_TONE) begin
            shift_ev_c = bus.tone2_posedge;
        end else begin
            shift_ev_c = bus.clk_en && div_wrap_c && !rate_sq;
        end
    end

    // Next state: a control write restarts everything and drops any coincident shift.
    always_comb begin
        fb_nxt      = fb_reg;
        nf_nxt      = nf_reg;
        divider_nxt = divider;
        rate_sq_nxt = rate_sq;
        lfsr_nxt    = lfsr;
        strobe_nxt  = 1'b0;

        if (bus.control_write) begin
            fb_nxt      = bus.control[2];
            nf_nxt      = bus.control[1:0];
            divider_nxt = '0;
            rate_sq_nxt = 1'b0;
            lfsr_nxt    = LFSR_SEED;
        end else begin
            if (bus.clk_en) begin
                if (div_wrap_c) begin
                    divider_nxt = '0;
                    rate_sq_nxt = !rate_sq;
                end else begin
                    divider_nxt = divider + DIV_W'(1);
                end
            end
            if (shift_ev_c) begin
                lfsr_nxt   = {fbk_c, lfsr[LFSR_BITS-1:1]};
                strobe_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_reg   <= 1'b0;
            nf_reg   <= 2'b00;
            divider  <= '0;
            rate_sq  <= 1'b0;
            lfsr     <= LFSR_SEED;
            strobe_q <= 1'b0;
        end else begin
            fb_reg   <= fb_nxt;
            nf_reg   <= nf_nxt;
            divider  <= divider_nxt;
            rate_sq  <= rate_sq_nxt;
            lfsr     <= lfsr_nxt;
            strobe_q <= strobe_nxt;
        end
    end

    assign bus.noise_out    = lfsr[0];
    assign bus.shift_strobe = strobe_q;
    assign bus.lfsr_state   = lfsr;
endmodule
